// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter: access size codes,
// FSM state encoding, memory lane mask and alignment helpers.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACC    = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_RMW_WR = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam logic [3:0] MEM_LANE_MASK = 4'b1111;

    // Reserved size behaves as a word, so it shares the word alignment rule.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            default: return addr_lo != 2'b00;
        endcase
    endfunction

    function automatic logic needs_rmw(input logic we, input size_e size, input logic [1:0] addr_lo);
        return we && ((size == SZ_BYTE) || (size == SZ_HALF)) && !is_misaligned(size, addr_lo);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the memory-side bus of the arbiter.
interface dmem_arbiter_if;

    logic        p0_req, p1_req;
    logic        p0_we, p1_we;
    logic [31:0] p0_addr, p1_addr;
    logic [1:0]  p0_size, p1_size;
    logic [31:0] p0_wdata, p1_wdata;
    logic        p0_gnt, p1_gnt;
    logic        p0_done, p1_done;
    logic [31:0] p0_rdata, p1_rdata;
    logic        p0_err, p1_err;

    logic        mem_ce, mem_we, mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_w_mask, mem_r_mask;
    logic [31:0] mem_rdata;

    modport slave (
        input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
               p0_size, p1_size, p0_wdata, p1_wdata, mem_rdata,
        output p0_gnt, p1_gnt, p0_done, p1_done, p0_rdata, p1_rdata,
               p0_err, p1_err, mem_ce, mem_we, mem_rd, mem_addr,
               mem_wdata, mem_w_mask, mem_r_mask
    );

    modport master (
        output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
               p0_size, p1_size, p0_wdata, p1_wdata, mem_rdata,
        input  p0_gnt, p1_gnt, p0_done, p1_done, p0_rdata, p1_rdata,
               p0_err, p1_err, mem_ce, mem_we, mem_rd, mem_addr,
               mem_wdata, mem_w_mask, mem_r_mask
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: merges sub-word store data into a full
// word and extracts zero-extended, right-aligned load data.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] old_word,
    input  logic [31:0] load_word,
    output logic [31:0] merged_word,
    output logic [31:0] load_data
);

    always_comb begin
        merged_word = old_word;
        load_data   = load_word;
        case (size)
            SZ_BYTE: begin
                merged_word[{addr_lo, 3'b000} +: 8] = store_data[7:0];
                load_data = {24'h0, load_word[{addr_lo, 3'b000} +: 8]};
            end
            SZ_HALF: begin
                merged_word[{addr_lo[1], 4'b0000} +: 16] = store_data[15:0];
                load_data = {16'h0, load_word[{addr_lo[1], 4'b0000} +: 16]};
            end
            default: begin
                merged_word = store_data;
                load_data   = load_word;
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin data-memory arbiter; sub-word stores are performed as
// read-modify-write on a 32-bit word memory with one transaction in flight.
module dmem_arbiter
    import dmem_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    size_e       size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;

    logic        gnt0, gnt1;
    logic        mis;
    logic        done0, done1;
    logic [31:0] merged_word, load_data;
    logic        mem_ce, mem_we, mem_rd;
    logic [31:0] mem_addr, mem_wdata;

    assign mis = is_misaligned(size_q, addr_q[1:0]);

    dmem_lane_align u_lane_align (
        .size        (size_q),
        .addr_lo     (addr_q[1:0]),
        .store_data  (wdata_q),
        .old_word    (merge_q),
        .load_word   (bus.mem_rdata),
        .merged_word (merged_word),
        .load_data   (load_data)
    );

    // last_q names the port granted most recently; on contention the other wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == ST_IDLE) begin
            if (bus.p0_req && (!bus.p1_req || last_q)) begin
                gnt0 = 1'b1;
            end else if (bus.p1_req) begin
                gnt1 = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        we_d      = we_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        merge_d   = merge_q;
        rdata_d   = rdata_q;
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        mem_rd    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            ST_IDLE: begin
                if (gnt0 || gnt1) begin
                    owner_d = gnt1;
                    last_d  = gnt1;
                    if (gnt1) begin
                        we_d    = bus.p1_we;
                        size_d  = size_e'(bus.p1_size);
                        addr_d  = bus.p1_addr;
                        wdata_d = bus.p1_wdata;
                    end else begin
                        we_d    = bus.p0_we;
                        size_d  = size_e'(bus.p0_size);
                        addr_d  = bus.p0_addr;
                        wdata_d = bus.p0_wdata;
                    end
                    state_d = needs_rmw(we_d, size_d, addr_d[1:0]) ? ST_RMW_RD : ST_ACC;
                end
            end
            ST_ACC: begin
                if (!mis) begin
                    mem_ce   = 1'b1;
                    mem_addr = {addr_q[31:2], 2'b00};
                    if (we_q) begin
                        mem_we    = 1'b1;
                        mem_wdata = wdata_q;
                    end else begin
                        mem_rd = 1'b1;
                    end
                end
                rdata_d = (!mis && !we_q) ? load_data : '0;
                state_d = ST_DONE;
            end
            ST_RMW_RD: begin
                mem_ce   = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = {addr_q[31:2], 2'b00};
                merge_d  = bus.mem_rdata;
                state_d  = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                mem_ce    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_wdata = merged_word;
                rdata_d   = '0;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
        end
    end

    assign done0 = (state_q == ST_DONE) && !owner_q;
    assign done1 = (state_q == ST_DONE) && owner_q;

    assign bus.p0_gnt     = gnt0;
    assign bus.p1_gnt     = gnt1;
    assign bus.p0_done    = done0;
    assign bus.p1_done    = done1;
    assign bus.p0_err     = done0 && mis;
    assign bus.p1_err     = done1 && mis;
    assign bus.p0_rdata   = done0 ? rdata_q : '0;
    assign bus.p1_rdata   = done1 ? rdata_q : '0;
    assign bus.mem_ce     = mem_ce;
    assign bus.mem_we     = mem_we;
    assign bus.mem_rd     = mem_rd;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;
    assign bus.mem_w_mask = MEM_LANE_MASK;
    assign bus.mem_r_mask = MEM_LANE_MASK;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a word memory model answers the memory
// bus, and each completion is checked against a queued expectation.
module tb_dmem_arbiter;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arbiter_if bus();

    dmem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem    [0:63];
    logic [31:0] shadow [0:63];
    exp_t        sb [$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          gnt_cyc = 0;
    int          ce_cnt = 0;
    int          we_cnt = 0;

    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_ce && bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [31:0] got_rdata;
        logic        got_err;
        if (bus.mem_ce) ce_cnt++;
        if (bus.mem_we) we_cnt++;
        if (bus.p0_gnt || bus.p1_gnt) gnt_cyc = cyc;
        if (bus.p0_done || bus.p1_done) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done got p0=%0b p1=%0b expected none", bus.p0_done, bus.p1_done);
            end else begin
                e = sb.pop_front();
                got_rdata = e.port ? bus.p1_rdata : bus.p0_rdata;
                got_err   = e.port ? bus.p1_err : bus.p0_err;
                if ({bus.p1_done, bus.p0_done} !== (e.port ? 2'b10 : 2'b01)) begin
                    failures++;
                    $display("FAIL done_port got=%b expected=%b", {bus.p1_done, bus.p0_done}, e.port ? 2'b10 : 2'b01);
                end
                checks++;
                if (got_rdata !== e.rdata) begin
                    failures++;
                    $display("FAIL done_rdata port=%0d got=%h expected=%h", e.port, got_rdata, e.rdata);
                end
                checks++;
                if (got_err !== e.err) begin
                    failures++;
                    $display("FAIL done_err port=%0d got=%0b expected=%0b", e.port, got_err, e.err);
                end
                checks++;
                if (cyc - gnt_cyc != e.lat) begin
                    failures++;
                    $display("FAIL done_latency port=%0d got=%0d expected=%0d", e.port, cyc - gnt_cyc, e.lat);
                end
                checks++;
                if ({bus.mem_ce, bus.mem_we, bus.mem_rd} !== 3'b000 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
                    failures++;
                    $display("FAIL done_mem_quiet got ce/we/rd=%b addr=%h wdata=%h expected all zero",
                             {bus.mem_ce, bus.mem_we, bus.mem_rd}, bus.mem_addr, bus.mem_wdata);
                end
            end
        end
    end

    task automatic set_port(input logic p, input logic req, input logic we, input logic [31:0] addr,
                            input logic [1:0] size, input logic [31:0] wdata);
        if (p == 1'b0) begin
            bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_size = size; bus.p0_wdata = wdata;
        end else begin
            bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_size = size; bus.p1_wdata = wdata;
        end
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_done_timeout pending=%0d expected=0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic issue(input logic p, input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_lat, input string name);
        exp_t e;
        logic got;
        @(posedge clk); #1;
        set_port(p, 1'b1, we, addr, size, wdata);
        e = '{port: p, rdata: exp_rdata, err: exp_err, lat: exp_lat};
        sb.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = p ? bus.p1_gnt : bus.p0_gnt;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s_grant got=0 expected=1", name);
            sb.delete();
            set_port(p, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
            return;
        end
        @(posedge clk); #1;
        set_port(p, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
        wait_idle(name);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({bus.p0_gnt, bus.p1_gnt, bus.p0_done, bus.p1_done, bus.p0_err, bus.p1_err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b expected=000000",
                     {bus.p0_gnt, bus.p1_gnt, bus.p0_done, bus.p1_done, bus.p0_err, bus.p1_err});
        end
        checks++;
        if ((bus.p0_rdata | bus.p1_rdata) !== 32'h0 || bus.mem_ce !== 1'b0 || bus.mem_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_data got rdata0=%h rdata1=%h ce=%0b addr=%h expected zeros",
                     bus.p0_rdata, bus.p1_rdata, bus.mem_ce, bus.mem_addr);
        end
        checks++;
        if (bus.mem_w_mask !== 4'hF || bus.mem_r_mask !== 4'hF) begin
            failures++;
            $display("FAIL masks got w=%h r=%h expected=f", bus.mem_w_mask, bus.mem_r_mask);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        exp_t e;
        int   n = 0;
        @(posedge clk); #1;
        set_port(1'b0, 1'b1, 1'b0, 32'h40, 2'd2, 32'h0);
        set_port(1'b1, 1'b1, 1'b0, 32'h44, 2'd2, 32'h0);
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            if (bus.p0_gnt || bus.p1_gnt) begin
                checks++;
                if ({bus.p1_gnt, bus.p0_gnt} !== ((n % 2) ? 2'b10 : 2'b01)) begin
                    failures++;
                    $display("FAIL rr_grant_%0d got=%b expected=%b", n, {bus.p1_gnt, bus.p0_gnt},
                             (n % 2) ? 2'b10 : 2'b01);
                end
                e = '{port: logic'(n % 2), rdata: (n % 2) ? 32'h1000_0011 : 32'h1000_0010, err: 1'b0, lat: 2};
                sb.push_back(e);
                n++;
            end
        end
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL rr_grant_count got=%0d expected=4", n);
        end
        @(posedge clk); #1;
        set_port(1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
        set_port(1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
        wait_idle("rr");
    endtask

    task automatic test_word();
        issue(1'b0, 1'b1, 32'h10, 2'd2, 32'hDEADBEEF, 32'h0, 1'b0, 2, "p0_st_word");
        checks++;
        if (mem[4] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL word_store_mem got=%h expected=deadbeef", mem[4]);
        end
        issue(1'b0, 1'b0, 32'h10, 2'd2, 32'h0, 32'hDEADBEEF, 1'b0, 2, "p0_ld_word");
    endtask

    task automatic test_byte();
        issue(1'b1, 1'b1, 32'h12, 2'd0, 32'h0000005A, 32'h0, 1'b0, 3, "p1_st_byte");
        checks++;
        if (mem[4] !== 32'hDE5ABEEF) begin
            failures++;
            $display("FAIL byte_store_mem got=%h expected=de5abeef", mem[4]);
        end
        issue(1'b1, 1'b0, 32'h12, 2'd0, 32'h0, 32'h0000005A, 1'b0, 2, "p1_ld_byte");
    endtask

    task automatic test_misaligned();
        int ce0, we0;
        @(posedge clk); #1;
        ce0 = ce_cnt;
        we0 = we_cnt;
        issue(1'b0, 1'b0, 32'h11, 2'd1, 32'h0, 32'h0, 1'b1, 2, "p0_ld_half_mis");
        issue(1'b1, 1'b1, 32'h13, 2'd3, 32'hFFFFFFFF, 32'h0, 1'b1, 2, "p1_st_rsvd_mis");
        @(posedge clk); #1;
        checks++;
        if (ce_cnt != ce0 || we_cnt != we0) begin
            failures++;
            $display("FAIL misaligned_strobes got ce=%0d we=%0d expected=0", ce_cnt - ce0, we_cnt - we0);
        end
        checks++;
        if (mem[4] !== 32'hDE5ABEEF) begin
            failures++;
            $display("FAIL misaligned_mem got=%h expected=de5abeef", mem[4]);
        end
    endtask

    task automatic test_half();
        mem[5] <= 32'h12345678;
        @(posedge clk);
        issue(1'b1, 1'b1, 32'h16, 2'd1, 32'h0000BEEF, 32'h0, 1'b0, 3, "p1_st_half");
        checks++;
        if (mem[5] !== 32'hBEEF5678) begin
            failures++;
            $display("FAIL half_store_mem got=%h expected=beef5678", mem[5]);
        end
        issue(1'b1, 1'b0, 32'h16, 2'd1, 32'h0, 32'h0000BEEF, 1'b0, 2, "p1_ld_half_hi");
        issue(1'b0, 1'b0, 32'h14, 2'd1, 32'h0, 32'h00005678, 1'b0, 2, "p0_ld_half_lo");
    endtask

    task automatic test_reset_mid_rmw();
        exp_t e;
        logic got = 1'b0;
        int   we0, ce0;
        mem[8] <= 32'hCAFEF00D;
        @(posedge clk); #1;
        set_port(1'b0, 1'b1, 1'b1, 32'h20, 2'd1, 32'h00001111);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = bus.p0_gnt;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL rmw_abort_grant got=0 expected=1");
        end
        @(posedge clk); #1;
        set_port(1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
        we0 = we_cnt;
        @(negedge clk);
        checks++;
        if ({bus.mem_ce, bus.mem_rd, bus.mem_we} !== 3'b110 || bus.mem_addr !== 32'h20) begin
            failures++;
            $display("FAIL rmw_rd_phase got ce/rd/we=%b addr=%h expected=110 addr=00000020",
                     {bus.mem_ce, bus.mem_rd, bus.mem_we}, bus.mem_addr);
        end
        #1 rst = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (we_cnt != we0 || mem[8] !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL rmw_abort got we_pulses=%0d word=%h expected 0 cafef00d", we_cnt - we0, mem[8]);
        end
        // Both ports request; p1 drops before its grant and must leave no trace.
        @(posedge clk); #1;
        ce0 = ce_cnt;
        set_port(1'b0, 1'b1, 1'b0, 32'h20, 2'd2, 32'h0);
        set_port(1'b1, 1'b1, 1'b1, 32'h24, 2'd2, 32'hFFFFFFFF);
        e = '{port: 1'b0, rdata: 32'hCAFEF00D, err: 1'b0, lat: 2};
        sb.push_back(e);
        @(negedge clk);
        checks++;
        if ({bus.p1_gnt, bus.p0_gnt} !== 2'b01) begin
            failures++;
            $display("FAIL post_reset_grant got=%b expected=01", {bus.p1_gnt, bus.p0_gnt});
        end
        @(posedge clk); #1;
        set_port(1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
        @(negedge clk);
        checks++;
        if (bus.p1_gnt !== 1'b0) begin
            failures++;
            $display("FAIL busy_no_grant got=%0b expected=0", bus.p1_gnt);
        end
        @(posedge clk); #1;
        set_port(1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
        wait_idle("post_reset_ld");
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ce_cnt - ce0 != 1 || mem[9] !== shadow[9]) begin
            failures++;
            $display("FAIL dropped_req got ce_pulses=%0d word9=%h expected 1 %h", ce_cnt - ce0, mem[9], shadow[9]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [7:0]  b;
        logic        p;
        for (int k = 0; k < 6; k++) begin
            a = 32'h80 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
            b = 8'($urandom);
            p = 1'($urandom_range(0, 1));
            shadow[a[7:2]][{a[1:0], 3'b000} +: 8] = b;
            issue(p, 1'b1, a, 2'd0, {24'hABCDEF, b}, 32'h0, 1'b0, 3, "b2b_st");
            issue(!p, 1'b0, a, 2'd0, 32'h0, {24'h0, b}, 1'b0, 2, "b2b_ld");
            checks++;
            if (mem[a[7:2]] !== shadow[a[7:2]]) begin
                failures++;
                $display("FAIL b2b_word addr=%h got=%h expected=%h", a, mem[a[7:2]], shadow[a[7:2]]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        set_port(1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
        set_port(1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
        for (int i = 0; i < 64; i++) begin
            mem[i]    <= 32'h1000_0000 + i;
            shadow[i]  = 32'h1000_0000 + i;
        end
        test_reset();
        test_round_robin();
        test_word();
        test_byte();
        test_misaligned();
        test_half();
        test_reset_mid_rmw();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters: none; memory word width fixed at 32 bits, byte lanes little-endian (lane 0 = bits 7:0).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 p0_req, p1_req  in  1 each  request valid, held until granted; port 0 = CPU load/store, port 1 = DMA/debug.
REQ-005 pN_we  in  1  1 = store, 0 = load.
REQ-006 pN_addr  in  32  byte address.
REQ-007 pN_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved (treated as word).
REQ-008 pN_wdata  in  32  store data, right-aligned (byte in 7:0, half in 15:0).
REQ-009 pN_gnt  out  1  request accepted this cycle.
REQ-010 pN_done  out  1  one-cycle completion pulse; pN_rdata/pN_err valid only with it.
REQ-011 pN_rdata  out  32  load data, zero-extended, right-aligned.
REQ-012 pN_err  out  1  misaligned access (half at addr[0]=1, word at addr[1:0]!=0).
REQ-013 mem_ce, mem_we, mem_rd  out  1 each  memory chip enable, write enable, read enable.
REQ-014 mem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
REQ-015 mem_wdata  out  32  full merged word; mem_w_mask, mem_r_mask  out  4  constant 4'b1111.
REQ-016 mem_rdata  in  32  combinational read data from memory.

Function
REQ-017 FSM states: IDLE, ACC, RMW_RD, RMW_WR, DONE.
REQ-018 In IDLE, gnt SHALL be asserted combinationally to exactly one requesting port; none if no req.
REQ-019 Arbitration SHALL be round-robin: on contention, grant the port not granted last; single requester always wins.
REQ-020 On a grant edge the port id, we, addr, size, wdata SHALL be latched; next state: RMW_RD for aligned byte/half store, ACC otherwise.
REQ-021 ACC: load -> mem_ce=1, mem_rd=1; word store -> mem_ce=1, mem_we=1, mem_wdata=wdata; misaligned -> no memory strobes; next state DONE.
REQ-022 RMW_RD: mem_ce=1, mem_rd=1, capture mem_rdata into merge register; next RMW_WR.
REQ-023 RMW_WR: mem_ce=1, mem_we=1, mem_wdata = captured word with lane(s) addr[1:0] (byte) or addr[1] half replaced by wdata; next DONE.
REQ-024 Load extraction SHALL use latched addr[1:0]/size: byte = mem_rdata lane addr[1:0], half = lanes {addr[1],1}/{addr[1],0}, zero-extended; captured at end of ACC.
REQ-025 DONE: done pulse (and err if misaligned) on the owning port only, rdata held from capture; next IDLE.
REQ-026 Latency grant-edge to done: load, word store, misaligned = 2 cycles; byte/half store = 3 cycles.
REQ-027 No new grant SHALL occur outside IDLE; at most one transaction outstanding.
REQ-028 Memory strobes SHALL be 0 and mem_wdata/mem_addr 0 in IDLE and DONE.
REQ-029 Requests deasserted before grant SHALL be dropped without side effect.

Reset
REQ-030 rst SHALL force IDLE, last-grant pointer = port 1 (so port 0 wins first contention), all gnt/done/err/rdata outputs 0, merge register 0.
REQ-031 Reset mid-RMW SHALL abort without issuing the write; no done pulse.

Structure
REQ-032 Shared package dmem_pkg SHALL hold size codes, FSM state encoding, and the 4'b1111 mask constant.
REQ-033 Lane merge/extract logic SHALL be one sub-module dmem_lane_align (combinational, store merge + load extract).

Verification
REQ-034 p0 word store 0xDEADBEEF @0x10, then p0 load word @0x10 -> done 2 cycles after each grant, rdata 0xDEADBEEF.
REQ-035 p1 byte store 0x5A @0x12 over 0xDEADBEEF -> 3-cycle done, memory word 0xDE5ABEEF; byte load @0x12 -> 0x0000005A.
REQ-036 p0 and p1 requesting every cycle after reset -> grants alternate p0, p1, p0, p1.
REQ-037 p0 half load @0x11 -> no mem_ce, done+err after 2 cycles, rdata 0.
REQ-038 rst asserted during RMW_RD of half store @0x20 -> no mem_we pulse, word unchanged, FSM IDLE.
REQ-039 p1 half store 0xBEEF @0x16 then half load @0x16 -> rdata 0x0000BEEF, lanes 0-1 of word 0x14 unchanged.
